xrun_seq: RTL and testbench
===========================

// Module: xrun_seq
// PURPOSE
//  Run sequencer directly upstream of the Versat data engine. On one start command it issues N
//  back-to-back engine runs: write 1 to engine control reg, wait settle, poll done bit, repeat.
//  Handshakes with config loader between runs (config_bus is shadowed at each run).
//  Passes host accesses to engine memories through while idle; owns the engine bus while busy.
// PARAMETERS
//  DATA_W      32  engine data/ctr bus width
//  ADDR_W      13  engine addr width (= nMEM_W+MEM_ADDR_W+1); MSB=1 selects control/status reg
//  CNT_W       16  run counter width
//  RUN_SETTLE  3   cycles after run write before first poll (engine run_reg + mem done drop)
//  TIMEOUT     2**20  max poll cycles per run (XRUN_SEQ_WDOG_EN only)
// PORTS
//  clk          in   1       clock
//  rst          in   1       async reset, active-low
//  start        in   1       pulse: begin sequence; ignored unless IDLE
//  nruns        in   CNT_W   runs to issue, sampled on accepted start
//  busy         out  1       high in every state except IDLE
//  runs_done    out  CNT_W   runs completed in current/last sequence
//  irq          out  1       level, set on sequence end; cleared by irq_clr or accepted start
//  irq_clr      in   1       pulse
//  cfg_req      out  1       request config loader to present next run's config_bus
//  cfg_ack      in   1       config_bus valid for next run (tie 1 if unused)
//  host_valid/host_we  in 1  host access to engine
//  host_addr    in   ADDR_W
//  host_wdata   in   DATA_W
//  host_rdata   out  DATA_W  = eng_rdata (always)
//  host_ready   out  1       1 in IDLE, else 0 (host must hold request)
//  eng_valid/eng_we out 1    engine valid/we
//  eng_addr     out  ADDR_W
//  eng_wdata    out  DATA_W  to engine write-data input
//  eng_rdata    in   DATA_W  from engine; bit0 = done when control reg addressed (same cycle)
//  wdog_err     out  1       timeout flag (XRUN_SEQ_WDOG_EN only)
// BEHAVIOUR
//  Reset: state IDLE; busy,irq,cfg_req,eng_valid,eng_we,wdog_err=0; runs_done=0; remaining=0.
//  IDLE: eng_* = host_* combinationally; host_ready=1. start -> latch nruns, runs_done<=0, irq<=0;
//   nruns==0 -> irq<=1 next cycle, stay IDLE; else -> CFG. Host access in start cycle completes.
//  CFG: cfg_req=1; cfg_ack sampled high -> RUN next cycle (cfg_req drops with state).
//  RUN (1 cycle): eng_valid=1, eng_we=1, eng_addr=CTRL={1,0..0}, eng_wdata=1 -> SETTLE, cnt<=0.
//  SETTLE: eng_valid=0; after RUN_SETTLE cycles -> POLL.
//  POLL: eng_valid=1, eng_we=0, eng_addr=CTRL; eng_rdata[0]==1 -> NEXT; else stay.
//  NEXT (1 cycle): runs_done+=1, remaining-=1; remaining was 1 -> IDLE with irq<=1; else -> CFG.
//  Latency, cfg_ack=1, engine done after D polls: start->first run write = 2 cycles;
//   per run = 1(CFG)+1(RUN)+RUN_SETTLE+D+1(NEXT).
//  irq_clr and set in same cycle: set wins. start while busy: ignored, no error.
//  eng_wdata=0 outside RUN while busy. Counters wrap never (nruns <= 2**CNT_W-1).
//  Reset mid-sequence: immediate return to reset values; engine run in flight is abandoned.
// CONFIGURATION
//  XRUN_SEQ_WDOG_EN defined: poll counter per run; reaching TIMEOUT in POLL -> wdog_err<=1,
//   irq<=1, IDLE; runs_done holds completed count; wdog_err cleared by accepted start.
//  Undefined: no counter, wdog_err port absent, POLL waits forever.
// STRUCTURE
//  Shared header xrunseqdefs.vh: state encodings (IDLE,CFG,RUN,SETTLE,POLL,NEXT), CTRL addr
//   constant, default TIMEOUT. Sub-module xrun_wdog (loadable down-counter + expire flag),
//   instantiated only under XRUN_SEQ_WDOG_EN; settle counter stays inline.
// TESTING
//  1 nruns=3, cfg_ack=1, done after 4 polls -> 3 ctrl writes of 1, runs_done=3, irq=1, busy=0.
//  2 nruns=0 -> no eng_valid, irq=1 one cycle after start, runs_done=0.
//  3 cfg_ack held low 10 cycles before run 2 -> cfg_req high 10+1 cycles, no run write meanwhile.
//  4 host read in IDLE addr=5 -> eng_addr=5 same cycle; host_valid while busy -> host_ready=0,
//    no host addr on eng_addr until IDLE.
//  5 rst low during POLL of run 2 -> all outputs reset values next edge; new start runs clean.
//  6 WDOG_EN, TIMEOUT=16, done never -> wdog_err=1, irq=1 after 16 poll cycles, runs_done=0.

Source files
------------

// File: rtl/xrun_seq_pkg.sv
// xrun_seq_pkg: shared state encoding, default watchdog limit and width helper for the run sequencer.
package xrun_seq_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_SETTLE, S_POLL, S_NEXT} state_t;

    localparam int TIMEOUT_DEF = 2**20;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xrun_seq_wdog.sv
// xrun_seq_wdog: loadable down-counter that flags expiry after TIMEOUT enabled cycles.
module xrun_seq_wdog import xrun_seq_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = cnt_w(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(TIMEOUT - 1);
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = r_cnt == '0;

endmodule

// File: rtl/xrun_seq.sv
// xrun_seq: issues N back-to-back engine runs per start, muxing host access through while idle.
// Optional poll watchdog and wdog_err port enabled by defining XRUN_SEQ_WDOG_EN.
module xrun_seq import xrun_seq_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 13,
    parameter int CNT_W      = 16,
    parameter int RUN_SETTLE = 3
`ifdef XRUN_SEQ_WDOG_EN
    , parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
`ifdef XRUN_SEQ_WDOG_EN
    output logic              wdog_err,
`endif
    input  logic              start,
    input  logic [CNT_W-1:0]  nruns,
    output logic              busy,
    output logic [CNT_W-1:0]  runs_done,
    output logic              irq,
    input  logic              irq_clr,
    output logic              cfg_req,
    input  logic              cfg_ack,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ready,
    output logic              eng_valid,
    output logic              eng_we,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [DATA_W-1:0] eng_wdata,
    input  logic [DATA_W-1:0] eng_rdata
);
    localparam int SW = cnt_w(RUN_SETTLE);
    localparam logic [ADDR_W-1:0] CTRL = {1'b1, {(ADDR_W-1){1'b0}}};

    state_t r_state, w_next;
    logic [CNT_W-1:0] r_remaining, r_runs_done;
    logic [SW-1:0] r_settle;
    logic r_irq;
    logic w_idle, w_accept, w_done, w_last, w_tmo;

    assign w_idle   = r_state == S_IDLE;
    assign w_accept = w_idle && start;
    assign w_done   = eng_rdata[0];
    assign w_last   = r_remaining == CNT_W'(1);

`ifdef XRUN_SEQ_WDOG_EN
    logic w_expired, r_wdog;

    xrun_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == S_RUN),
        .i_en      (r_state == S_POLL),
        .o_expired (w_expired)
    );

    assign w_tmo = r_state == S_POLL && !w_done && w_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_wdog <= 1'b0;
        else
            r_wdog <= w_tmo ? 1'b1 : w_accept ? 1'b0 : r_wdog;
    end

    assign wdog_err = r_wdog;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (start && nruns != '0) ? S_CFG : S_IDLE;
            S_CFG:    w_next = cfg_ack ? S_RUN : S_CFG;
            S_RUN:    w_next = S_SETTLE;
            S_SETTLE: w_next = (r_settle == SW'(RUN_SETTLE - 1)) ? S_POLL : S_SETTLE;
            S_POLL:   w_next = w_done ? S_NEXT : w_tmo ? S_IDLE : S_POLL;
            S_NEXT:   w_next = w_last ? S_IDLE : S_CFG;
            default:  w_next = S_IDLE;
        endcase
    end

    // irq set sources take priority over the clear sources
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_runs_done <= '0;
            r_settle    <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_remaining <= nruns;
                r_runs_done <= '0;
            end else if (r_state == S_NEXT) begin
                r_remaining <= r_remaining - 1'b1;
                r_runs_done <= r_runs_done + 1'b1;
            end
            r_settle <= (r_state == S_SETTLE) ? r_settle + 1'b1 : '0;
            r_irq    <= ((w_accept && nruns == '0) || (r_state == S_NEXT && w_last) || w_tmo) ? 1'b1 :
                        (w_accept || irq_clr) ? 1'b0 : r_irq;
        end
    end

    always_comb begin
        busy       = !w_idle;
        host_ready = w_idle;
        cfg_req    = r_state == S_CFG;
        irq        = r_irq;
        runs_done  = r_runs_done;
        host_rdata = eng_rdata;
        eng_valid  = w_idle ? host_valid : (r_state == S_RUN || r_state == S_POLL);
        eng_we     = w_idle ? host_we : r_state == S_RUN;
        eng_addr   = w_idle ? host_addr : CTRL;
        eng_wdata  = w_idle ? host_wdata : DATA_W'(r_state == S_RUN);
    end

endmodule

// File: tb/tb_xrun_seq.sv
// tb_xrun_seq: scoreboard bench for xrun_seq with a small engine model answering done after D polls.
module tb_xrun_seq;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int CNT_W  = 16;
    localparam int D      = 4;
    localparam logic [ADDR_W-1:0] CTRL = 13'h1000;

    logic clk = 1'b0;
    logic rst, start, irq_clr, cfg_ack, host_valid, host_we;
    logic busy, irq, cfg_req, host_ready, eng_valid, eng_we;
    logic [CNT_W-1:0] nruns, runs_done;
    logic [ADDR_W-1:0] host_addr, eng_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata, eng_wdata, eng_rdata;
`ifdef XRUN_SEQ_WDOG_EN
    logic wdog_err;
`endif

    xrun_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RUN_SETTLE(3)
`ifdef XRUN_SEQ_WDOG_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef XRUN_SEQ_WDOG_EN
        .wdog_err   (wdog_err),
`endif
        .start      (start),
        .nruns      (nruns),
        .busy       (busy),
        .runs_done  (runs_done),
        .irq        (irq),
        .irq_clr    (irq_clr),
        .cfg_req    (cfg_req),
        .cfg_ack    (cfg_ack),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ready (host_ready),
        .eng_valid  (eng_valid),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .eng_rdata  (eng_rdata)
    );

    always #5 clk = ~clk;

    // engine model: a control write restarts the run, done shows on the D-th poll
    logic [7:0] polls = 8'd0;
    logic never_done;

    always @(posedge clk)
        if (eng_valid && eng_addr == CTRL)
            polls <= eng_we ? 8'd0 : (polls == 8'hff ? polls : polls + 8'd1);

    always_comb
        eng_rdata = (eng_addr == CTRL) ? {31'd0, !never_done && polls >= 8'(D - 1)}
                                       : 32'h5A5A_0000 ^ 32'(eng_addr);

    int total = 0, bad = 0, cyc = 0;
    int wr_seen, first_wr, busy_cyc, req_cyc, poll_cyc, st_cyc;
    logic irq_q;
    logic [44:0] wq[$];
    logic [CNT_W-1:0] dq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // one clock: advance to the falling edge and run the bus monitor / scoreboard
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst) begin
            if (busy && eng_valid && eng_we) begin
                wr_seen++;
                if (first_wr < 0) first_wr = cyc;
                if (wq.size() == 0) chk("wq_extra", 64'(wq.size()), 1);
                else chk("ctrl_wr", {eng_addr, eng_wdata}, wq.pop_front());
            end
            if (busy) begin
                busy_cyc++;
                chk("busy_ready", host_ready, 0);
                if (eng_valid) chk("busy_addr", eng_addr, CTRL);
                if (!(eng_valid && eng_we)) chk("busy_wdata", eng_wdata, 0);
            end
            if (cfg_req) req_cyc++;
            if (busy && eng_valid && !eng_we) poll_cyc++;
            if (irq && !irq_q) begin
                if (dq.size() == 0) chk("dq_extra", 64'(dq.size()), 1);
                else chk("runs_done_irq", runs_done, dq.pop_front());
            end
        end
        irq_q = irq;
    endtask

    task automatic go(input int n, input int nw, input int rd);
        wr_seen = 0; first_wr = -1; busy_cyc = 0; req_cyc = 0; poll_cyc = 0; st_cyc = cyc;
        for (int i = 0; i < nw; i++) wq.push_back({CTRL, 32'd1});
        dq.push_back(CNT_W'(rd));
        nruns = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        chk("seq_end", busy, 0);
    endtask

    initial begin
        int n;
        rst = 0; start = 0; nruns = 0; irq_clr = 0; cfg_ack = 1; never_done = 0;
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0; irq_q = 0; first_wr = -1;
        wr_seen = 0; busy_cyc = 0; req_cyc = 0; poll_cyc = 0; st_cyc = 0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cfg_req", cfg_req, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_eng_we", eng_we, 0);
        chk("rst_runs_done", runs_done, 0);
        chk("rst_host_ready", host_ready, 1);
        rst = 1;
        tick();

        // three runs, done after D polls each
        go(3, 3, 3);
        wait_idle(200);
        chk("t1_latency", 64'(first_wr - st_cyc), 2);
        chk("t1_busy_cyc", 64'(busy_cyc), 3 * (1 + 1 + 3 + D + 1));
        chk("t1_writes", 64'(wr_seen), 3);
        chk("t1_polls", 64'(poll_cyc), 3 * D);
        chk("t1_runs_done", runs_done, 3);
        chk("t1_irq", irq, 1);
        chk("t1_wq_left", 64'(wq.size()), 0);
        irq_clr = 1;
        tick();
        irq_clr = 0;
        chk("t1_irq_clr", irq, 0);

        // zero runs, with a simultaneous irq_clr that the set must override
        irq_clr = 1;
        go(0, 0, 0);
        irq_clr = 0;
        chk("t2_irq", irq, 1);
        chk("t2_busy", busy, 0);
        chk("t2_runs_done", runs_done, 0);
        chk("t2_valid", eng_valid, 0);
        tick();
        chk("t2_writes", 64'(wr_seen), 0);
        irq_clr = 1;
        tick();
        irq_clr = 0;
        chk("t2_irq_clr", irq, 0);

        // config loader stalls 10 cycles before run 2
        go(2, 2, 2);
        n = 0;
        while (wr_seen < 1 && n < 100) begin tick(); n++; end
        cfg_ack = 0;
        while (runs_done != 1 && n < 100) begin tick(); n++; end
        repeat (10) tick();
        chk("t3_no_wr", 64'(wr_seen), 1);
        chk("t3_cfg_req", cfg_req, 1);
        cfg_ack = 1;
        wait_idle(200);
        chk("t3_req_cyc", 64'(req_cyc), 1 + 11);
        chk("t3_runs_done", runs_done, 2);

        // host pass-through in idle, blocked while busy
        irq_clr = 1;
        tick();
        irq_clr = 0;
        host_valid = 1; host_we = 0; host_addr = 13'd5;
        #1;
        chk("t4_addr", eng_addr, 5);
        chk("t4_valid", eng_valid, 1);
        chk("t4_we", eng_we, 0);
        chk("t4_ready", host_ready, 1);
        chk("t4_rdata", host_rdata, 32'h5A5A_0005);
        host_we = 1; host_addr = 13'd7; host_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t4_wdata", eng_wdata, 32'hDEAD_BEEF);
        chk("t4_wr_we", eng_we, 1);
        host_we = 0; host_addr = 13'd5;
        go(1, 1, 1);
        wait_idle(100);
        chk("t4_back_addr", eng_addr, 5);
        chk("t4_back_ready", host_ready, 1);
        host_valid = 0;

        // reset during the polling of run 2
        go(3, 3, 3);
        n = 0;
        while (!(runs_done == 1 && eng_valid && !eng_we) && n < 100) begin tick(); n++; end
        chk("t5_reached_poll", runs_done, 1);
        rst = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_runs_done", runs_done, 0);
        chk("t5_cfg_req", cfg_req, 0);
        chk("t5_eng_valid", eng_valid, 0);
        chk("t5_irq", irq, 0);
        wq.delete();
        dq.delete();
        tick();
        chk("t5_busy_held", busy, 0);
        rst = 1;
        tick();
        go(2, 2, 2);
        wait_idle(200);
        chk("t5_latency", 64'(first_wr - st_cyc), 2);
        chk("t5_writes", 64'(wr_seen), 2);
        chk("t5_new_runs", runs_done, 2);

`ifdef XRUN_SEQ_WDOG_EN
        // engine never finishes: watchdog ends the sequence
        never_done = 1;
        go(2, 1, 0);
        wait_idle(100);
        chk("t6_wdog", wdog_err, 1);
        chk("t6_irq", irq, 1);
        chk("t6_runs_done", runs_done, 0);
        chk("t6_polls", 64'(poll_cyc), 16);
        never_done = 0;
        go(1, 1, 1);
        chk("t6_wdog_clr", wdog_err, 0);
        wait_idle(100);
        chk("t6_runs_after", runs_done, 1);
`endif

        chk("end_wq_left", 64'(wq.size()), 0);
        chk("end_dq_left", 64'(dq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
